// File: rtl/pin_edge_gen.sv
// Timestamped edge generator: queues (time, phase, level) events and renders them as 8-bit serializer words.
// Optional define PIN_EDGE_GEN_DUP_FILT_EN drops events that would not change the pin level.
module pin_edge_gen #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16
) (
  input  logic            clk300,
  input  logic            rst_n,
  input  logic            en,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic [TS_W-1:0] ev_time,
  input  logic [2:0]      ev_ptime,
  input  logic            ev_level,
  output logic [7:0]      ser_word,
  output logic            pin_level,
  output logic [TS_W-1:0] tcnt,
  output logic            late_err,
  output logic            busy,
  output logic            dup_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_W + 4;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic {IDLE, ARMED} state_t;

  state_t          state_reg, state_next;
  logic [EW-1:0]   mem_reg [DEPTH];
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg, count;
  logic [TS_W-1:0] tcnt_reg;
  logic [7:0]      ser_word_reg;
  logic            pin_level_reg;
  logic            late_err_reg;

  logic            full, empty, push, store, pop, is_late, is_dup;
  logic [TS_W-1:0] head_time, d;
  logic [2:0]      head_ptime, ptime_eff;
  logic            head_level;
  logic [7:0]      word_next;

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = ev_valid && !full;
  assign store = push && !is_dup;

  assign {head_level, head_ptime, head_time} = mem_reg[rd_ptr_reg[AW-1:0]];

  // Modular distance: upper half of the range means the head is already in the past.
  assign d         = head_time - tcnt_reg;
  assign pop       = (state_reg == ARMED) && en && ((d == '0) || d[TS_W-1]);
  assign is_late   = pop && (d != '0);
  assign ptime_eff = is_late ? 3'd0 : head_ptime;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign word_next[gi] = (3'(gi) < ptime_eff) ? pin_level_reg : head_level;
    end
  endgenerate

`ifdef PIN_EDGE_GEN_DUP_FILT_EN
  logic [AW-1:0] tail_idx;
  logic          ref_level;
  logic          dup_drop_reg;

  // Reference is the level the pin will have once everything queued has been emitted.
  assign tail_idx  = wr_ptr_reg[AW-1:0] - AW'(1);
  assign ref_level = empty ? pin_level_reg : mem_reg[tail_idx][EW-1];
  assign is_dup    = push && (ev_level == ref_level);
  assign dup_drop  = dup_drop_reg;

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) dup_drop_reg <= 1'b0;
    else        dup_drop_reg <= is_dup;
  end
`else
  assign is_dup   = 1'b0;
  assign dup_drop = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (store) state_next = ARMED;
      ARMED: if (pop && !store && (count == (AW+1)'(1))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk300) begin
    if (store) mem_reg[wr_ptr_reg[AW-1:0]] <= {ev_level, ev_ptime, ev_time};
  end

  always_ff @(posedge clk300 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      tcnt_reg      <= '0;
      ser_word_reg  <= 8'h00;
      pin_level_reg <= 1'b0;
      late_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      late_err_reg <= is_late;
      if (en)    tcnt_reg   <= tcnt_reg + TS_W'(1);
      if (store) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + (AW+1)'(1);
        ser_word_reg  <= word_next;
        pin_level_reg <= head_level;
      end else begin
        ser_word_reg  <= {8{pin_level_reg}};
      end
    end
  end

  assign ev_ready  = !full;
  assign ser_word  = ser_word_reg;
  assign pin_level = pin_level_reg;
  assign tcnt      = tcnt_reg;
  assign late_err  = late_err_reg;
  assign busy      = (state_reg == ARMED);

endmodule

// File: tb/tb_pin_edge_gen.sv
// Directed bench for pin_edge_gen: a TS_W=16 instance for the main sequence, a TS_W=4 instance for wrap.
module tb_pin_edge_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_en = 1'b0, a_valid = 1'b0, a_ready, a_level = 1'b0;
  logic [15:0] a_time = '0, a_tcnt;
  logic [2:0]  a_ptime = '0;
  logic [7:0]  a_word;
  logic        a_pin, a_late, a_busy, a_dup;

  logic        b_en = 1'b0, b_valid = 1'b0, b_ready, b_level = 1'b0;
  logic [3:0]  b_time = '0, b_tcnt;
  logic [2:0]  b_ptime = '0;
  logic [7:0]  b_word;
  logic        b_pin, b_late, b_busy, b_dup;

  int n_chk = 0;
  int n_pass = 0;

  pin_edge_gen #(.DEPTH(4), .TS_W(16)) dut_a (
    .clk300(clk), .rst_n(rst_n), .en(a_en), .ev_valid(a_valid), .ev_ready(a_ready),
    .ev_time(a_time), .ev_ptime(a_ptime), .ev_level(a_level), .ser_word(a_word),
    .pin_level(a_pin), .tcnt(a_tcnt), .late_err(a_late), .busy(a_busy), .dup_drop(a_dup)
  );

  pin_edge_gen #(.DEPTH(4), .TS_W(4)) dut_b (
    .clk300(clk), .rst_n(rst_n), .en(b_en), .ev_valid(b_valid), .ev_ready(b_ready),
    .ev_time(b_time), .ev_ptime(b_ptime), .ev_level(b_level), .ser_word(b_word),
    .pin_level(b_pin), .tcnt(b_tcnt), .late_err(b_late), .busy(b_busy), .dup_drop(b_dup)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_a(input int t);
    int n = 0;
    while (a_tcnt != 16'(t) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_a_tcnt", 32'(a_tcnt), 32'(t));
  endtask

  task automatic wait_b(input int t);
    int n = 0;
    while (b_tcnt != 4'(t) && n < 200) begin
      tick();
      n++;
    end
    chk("wait_b_tcnt", 32'(b_tcnt), 32'(t));
  endtask

  task automatic drive_a(input int t, input int p, input logic l);
    a_valid = 1'b1;
    a_time  = 16'(t);
    a_ptime = 3'(p);
    a_level = l;
  endtask

  initial begin
    // reset values
    tick(); tick();
    chk("rst_tcnt", 32'(a_tcnt), 0);
    chk("rst_word", 32'(a_word), 32'h00);
    chk("rst_pin", 32'(a_pin), 0);
    chk("rst_late", 32'(a_late), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_dup", 32'(a_dup), 0);
    chk("rst_ready", 32'(a_ready), 1);

    // on-time rising edge, ptime 3
    rst_n = 1'b1;
    a_en  = 1'b1;
    drive_a(10, 3, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("t1_tcnt1", 32'(a_tcnt), 1);
    wait_a(10);
    chk("t1_word_before", 32'(a_word), 32'h00);
    chk("t1_busy_before", 32'(a_busy), 1);
    tick();
    chk("t1_word", 32'(a_word), 32'hF8);
    chk("t1_pin", 32'(a_pin), 1);
    chk("t1_late", 32'(a_late), 0);
    chk("t1_busy_after", 32'(a_busy), 0);

    // falling edge, ptime 5
    drive_a(20, 5, 1'b0);
    tick();
    a_valid = 1'b0;
    wait_a(20);
    chk("t2_word_before", 32'(a_word), 32'hFF);
    tick();
    chk("t2_word", 32'(a_word), 32'h1F);
    chk("t2_late", 32'(a_late), 0);
    tick();
    chk("t2_word_after", 32'(a_word), 32'h00);

    // reset with an event still queued
    drive_a(40, 2, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("mr_busy_pre", 32'(a_busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mr_tcnt", 32'(a_tcnt), 0);
    chk("mr_busy", 32'(a_busy), 0);
    chk("mr_ready", 32'(a_ready), 1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_busy_post", 32'(a_busy), 0);

    // late event: time 5 pushed at tcnt 8
    wait_a(8);
    drive_a(5, 6, 1'b1);
    tick();
    a_valid = 1'b0;
    chk("t3_word_pre", 32'(a_word), 32'h00);
    chk("t3_late_pre", 32'(a_late), 0);
    chk("t3_busy_pre", 32'(a_busy), 1);
    tick();
    chk("t3_word", 32'(a_word), 32'hFF);
    chk("t3_late", 32'(a_late), 1);
    chk("t3_pin", 32'(a_pin), 1);
    tick();
    chk("t3_late_post", 32'(a_late), 0);
    chk("t3_tcnt", 32'(a_tcnt), 11);

    // fill FIFO with en=0, fifth held off
    a_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(14 + i, 4, logic'(i % 2));
      chk("t4_ready_fill", 32'(a_ready), 1);
      tick();
    end
    drive_a(18, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_ready_full", 32'(a_ready), 0);
      chk("t4_word_hold", 32'(a_word), 32'hFF);
      chk("t4_tcnt_hold", 32'(a_tcnt), 11);
      tick();
    end
    a_en = 1'b1;
    tick(); tick(); tick();
    chk("t4_tcnt14", 32'(a_tcnt), 14);
    chk("t4_ready14", 32'(a_ready), 0);
    tick();
    chk("t4_word15", 32'(a_word), 32'h0F);
    chk("t4_ready15", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    chk("t4_word16", 32'(a_word), 32'hF0);
    tick();
    chk("t4_word17", 32'(a_word), 32'h0F);
    tick();
    chk("t4_word18", 32'(a_word), 32'hF0);
    tick();
    chk("t4_word19", 32'(a_word), 32'h0F);
    chk("t4_busy19", 32'(a_busy), 0);
    chk("t4_late19", 32'(a_late), 0);

    // redundant level then real edge (pin_level is 0 here)
    drive_a(30, 1, 1'b0);
    tick();
    drive_a(31, 3, 1'b1);
`ifdef PIN_EDGE_GEN_DUP_FILT_EN
    chk("t6_dup", 32'(a_dup), 1);
    chk("t6_busy_drop", 32'(a_busy), 0);
`else
    chk("t6_dup", 32'(a_dup), 0);
    chk("t6_busy_drop", 32'(a_busy), 1);
`endif
    tick();
    a_valid = 1'b0;
    chk("t6_dup_clear", 32'(a_dup), 0);
    chk("t6_busy", 32'(a_busy), 1);
    wait_a(31);
    chk("t6_word31", 32'(a_word), 32'h00);
    chk("t6_busy31", 32'(a_busy), 1);
    tick();
    chk("t6_word32", 32'(a_word), 32'hF8);
    chk("t6_pin32", 32'(a_pin), 1);
    chk("t6_busy32", 32'(a_busy), 0);

    // two events with the same time: second goes out late
    drive_a(40, 2, 1'b0);
    tick();
    drive_a(40, 5, 1'b1);
    tick();
    a_valid = 1'b0;
    wait_a(40);
    chk("t7_word40", 32'(a_word), 32'hFF);
    tick();
    chk("t7_word41", 32'(a_word), 32'h03);
    chk("t7_late41", 32'(a_late), 0);
    tick();
    chk("t7_word42", 32'(a_word), 32'hFF);
    chk("t7_late42", 32'(a_late), 1);
    chk("t7_pin42", 32'(a_pin), 1);
    tick();
    chk("t7_late43", 32'(a_late), 0);
    chk("t7_busy43", 32'(a_busy), 0);

    // wrap on the 4-bit timer
    b_en = 1'b1;
    wait_b(14);
    b_valid = 1'b1;
    b_time  = 4'd1;
    b_ptime = 3'd2;
    b_level = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("t5_late15", 32'(b_late), 0);
    chk("t5_busy15", 32'(b_busy), 1);
    tick();
    chk("t5_tcnt_wrap", 32'(b_tcnt), 0);
    chk("t5_late0", 32'(b_late), 0);
    chk("t5_word0", 32'(b_word), 32'h00);
    tick();
    chk("t5_word1", 32'(b_word), 32'h00);
    chk("t5_busy1", 32'(b_busy), 1);
    tick();
    chk("t5_word2", 32'(b_word), 32'hFC);
    chk("t5_late2", 32'(b_late), 0);
    chk("t5_pin2", 32'(b_pin), 1);
    chk("t5_busy2", 32'(b_busy), 0);
    chk("t5_dup2", 32'(b_dup), 0);
    chk("t5_ready2", 32'(b_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pin_edge_gen.md
Name: pin_edge_gen

Overview:
- Transmit-side counterpart of pin_capt: turns timestamped edge events (coarse cycle plus 3-bit fine phase) into an 8-bit parallel word per clk300 cycle.
- The word feeds an 8:1 output serializer running from clk600/clk600_90 DDR, so one bit = 1/8 of a clk300 period.
- Fine phase ptime has the same meaning as on the capture side.
- A small event FIFO decouples the event source from output timing.

Parameters:
- DEPTH, 4, event FIFO depth (power of 2, >=2).
- TS_W, 16, width of coarse timestamp and timer.

Ports:
- clk300  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  timer/emission enable.
- ev_valid  input  1  event offered.
- ev_ready  output  1  FIFO can accept; equals !full.
- ev_time  input  TS_W  coarse cycle in which the edge is placed.
- ev_ptime  input  3  fine phase 0..7 within that cycle.
- ev_level  input  1  pin level after the edge.
- ser_word  output  8  serializer word; bit 0 transmitted first.
- pin_level  output  1  current steady pin level.
- tcnt  output  TS_W  coarse timer.
- late_err  output  1  one-cycle pulse: event emitted late.
- busy  output  1  FIFO non-empty.
- dup_drop  output  1  one-cycle pulse: redundant event dropped (optional feature).

Behaviour:
- Reset (async assert, sync release): FIFO empty, tcnt=0, ser_word=8'h00, pin_level=0, late_err=0, dup_drop=0, busy=0, state IDLE.
- Timer:
  - tcnt increments by 1 each cycle with en=1 and wraps 2^TS_W-1 -> 0.
  - tcnt holds when en=0.
- FIFO:
  - Push on ev_valid && ev_ready.
  - A pushed entry becomes head visible the cycle after the push.
  - Push and pop in the same cycle are both allowed when not full.
  - When full, ev_ready=0; no push.
- State machine:
  - IDLE (FIFO empty) -> ARMED when head is valid.
  - ARMED -> IDLE after a pop that leaves the FIFO empty.
  - busy = (state==ARMED).
- Timing test in ARMED with en=1, using d = (head.time - tcnt) mod 2^TS_W:
  - d==0: on-time emit.
  - d >= 2^(TS_W-1): late emit. ptime is forced to 0 and late_err pulses in the same cycle as ser_word is updated.
  - Otherwise: wait.
- Emit (registered):
  - ser_word[i] = (i < ptime) ? pin_level : head.level, for i = 0..7.
  - pin_level <= head.level; pop head.
  - At most one pop per cycle.
  - For an event at time T, the word is visible on ser_word while tcnt==T+1 (1-cycle latency).
- No emit: ser_word <= {8{pin_level}}.
  - This applies to IDLE, waiting, and all cycles with en=0.
  - With en=0 there is no emission and no late test; the FIFO still accepts events.
- Boundary cases:
  - Two events with the same ev_time: the first is on time; the second emits late in the following cycle with late_err.
  - Event pushed while tcnt already equals its time: emitted late next cycle.
  - ptime=0 with head.level != pin_level: whole word is the new level.
  - Event with level equal to pin_level: word is constant. Still popped; no late_err unless late.
  - Wrap: an event at time 0 queued while tcnt=2^TS_W-2 is waiting (d=2), not late.
  - Reset mid-operation: FIFO contents discarded, outputs return to reset values immediately.

Optional Feature:
- Macro: PIN_EDGE_GEN_DUP_FILT_EN.
- Defined:
  - At push, an event whose ev_level equals the level of the most recently accepted event is acknowledged (ev_ready handshake completes) but not stored.
  - dup_drop pulses 1 cycle later.
  - The reference level is pin_level when the FIFO is empty, else the tail entry level.
- Not defined: every handshaked event is stored; dup_drop tied 0.

Test Plan:
- Reset, en=1, push {time=10, ptime=3, level=1} -> at tcnt==11, ser_word=8'b11111000, pin_level=1, late_err=0, busy falls.
- Push {time=20, ptime=5, level=0} while pin_level=1 -> at tcnt==21, ser_word=8'b00011111; cycles before and after: 8'hFF then 8'h00.
- Push {time=5, ptime=6, level=1} when tcnt=8 -> next-cycle ser_word=8'hFF, late_err single pulse, ptime ignored.
- Push DEPTH=4 events with en=0 -> ev_ready=0 after the 4th; 5th held until en=1 and first pop; ser_word constant throughout.
- TS_W=4: tcnt=14, push {time=1, ptime=2, level=1} -> no late_err, wraps, emitted with ser_word=8'b11111100 at tcnt==2.
- With PIN_EDGE_GEN_DUP_FILT_EN, pin_level=0, push level=0 then level=1 -> first dropped (dup_drop pulse, busy stays 0), second stored and emitted; without the macro, both are emitted, the first as 8'h00.
